// File: rtl/isqrt_arb_pkg.sv
// Shared constants for the isqrt round-robin front end.
//   ISQRT_W           operand/result width of the shared isqrt
//   ISQRT_LAT_DEFAULT default isqrt pipeline depth
//   MAX_REQ           largest supported requester count
//   TAG_W             requester-index width (sized for MAX_REQ)
//   GCNT_W / GCNT_MAX grant-counter width and saturation value
package isqrt_arb_pkg;
    localparam int ISQRT_W           = 32;
    localparam int ISQRT_LAT_DEFAULT = 16;
    localparam int MAX_REQ           = 8;
    localparam int TAG_W             = $clog2(MAX_REQ);
    localparam int GCNT_W            = 16;
    localparam logic [GCNT_W-1:0] GCNT_MAX = '1;
endpackage

// File: rtl/isqrt_arbiter_if.sv
// Requester-side bundle of the isqrt arbiter.
//   req_vld / req_x : per-requester operand valid and operand
//   req_rdy         : per-requester accept (one-hot or zero)
//   rsp_vld / rsp_y : one-hot result strobe and shared result
// master = requester side, slave = arbiter side.
interface isqrt_arbiter_if import isqrt_arb_pkg::*; #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]              req_vld;
    logic [N_REQ-1:0][ISQRT_W-1:0] req_x;
    logic [N_REQ-1:0]              req_rdy;
    logic [N_REQ-1:0]              rsp_vld;
    logic [ISQRT_W-1:0]            rsp_y;

    modport master (output req_vld, req_x, input req_rdy, rsp_vld, rsp_y);
    modport slave  (input req_vld, req_x, output req_rdy, rsp_vld, rsp_y);
endinterface

// File: rtl/isqrt_arb_rr.sv
// Combinational round-robin grant.
//   req          : request vector
//   last_granted : index of the most recent winner
//   grant        : one-hot winner, zero when no request
//   next_ptr     : winner index (holds last_granted when no request)
// Search starts at last_granted+1 and wraps from N_REQ-1 to 0.
module isqrt_arb_rr import isqrt_arb_pkg::*; #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [TAG_W-1:0] last_granted,
    output logic [N_REQ-1:0] grant,
    output logic [TAG_W-1:0] next_ptr
);
    // Walk priority from lowest to highest so the nearest requester
    // after the pointer is the last (winning) assignment.
    always_comb begin
        grant    = '0;
        next_ptr = last_granted;
        for (int k = N_REQ; k >= 1; k--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && ((int'(last_granted) + k) % N_REQ == i)) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    next_ptr = TAG_W'(i);
                end
            end
        end
    end
endmodule

// File: rtl/isqrt_arbiter.sv
// Round-robin front end sharing one pipelined isqrt among N_REQ requesters.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : req_vld/req_x/req_rdy/rsp_vld/rsp_y
//   sq_x_vld, sq_x  : operand to the isqrt
//   sq_y_vld, sq_y  : result from the isqrt (LATENCY cycles after sq_x_vld)
//   err             : sticky flag, isqrt valid disagreed with the tag pipe
//   grant_cnt       : per-requester saturating grant counters
// Macro ISQRT_ARBITER_PERF_EN enables grant_cnt; otherwise it is tied to 0.
module isqrt_arbiter import isqrt_arb_pkg::*; #(
    parameter int N_REQ   = 3,
    parameter int LATENCY = ISQRT_LAT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    isqrt_arbiter_if.slave               bus,
    output logic                         sq_x_vld,
    output logic [ISQRT_W-1:0]           sq_x,
    input  logic                         sq_y_vld,
    input  logic [ISQRT_W-1:0]           sq_y,
    output logic                         err,
    output logic [N_REQ-1:0][GCNT_W-1:0] grant_cnt
);
    logic [N_REQ-1:0]            req_gated;
    logic [N_REQ-1:0]            grant;
    logic [TAG_W-1:0]            last_granted;
    logic [TAG_W-1:0]            next_ptr;
    logic                        any_grant;
    logic [ISQRT_W-1:0]          sel_x;
    // Stage 0 is the sq_x_vld register; stage LATENCY lines up with sq_y_vld.
    logic [LATENCY:0]            vld_pipe;
    logic [LATENCY:0][TAG_W-1:0] tag_pipe;
    logic                        out_vld;
    logic [TAG_W-1:0]            out_tag;

    // No accepts while in reset.
    assign req_gated = bus.req_vld & {N_REQ{rst_n}};

    isqrt_arb_rr #(.N_REQ(N_REQ)) u_rr (
        .req          (req_gated),
        .last_granted (last_granted),
        .grant        (grant),
        .next_ptr     (next_ptr)
    );

    assign bus.req_rdy = grant;
    assign any_grant   = |grant;

    always_comb begin
        sel_x = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant[i]) sel_x = sel_x | bus.req_x[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         last_granted <= TAG_W'(N_REQ - 1);
        else if (any_grant) last_granted <= next_ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[LATENCY-1:0], any_grant};
    end

    // Datapath flops load only with a valid beside them, so idle
    // cycles leave operand and tags frozen.
    always_ff @(posedge clk) begin
        if (any_grant) begin
            sq_x        <= sel_x;
            tag_pipe[0] <= next_ptr;
        end
        for (int i = 1; i <= LATENCY; i++)
            if (vld_pipe[i-1]) tag_pipe[i] <= tag_pipe[i-1];
    end

    assign sq_x_vld = vld_pipe[0];
    assign out_vld  = vld_pipe[LATENCY];
    assign out_tag  = tag_pipe[LATENCY];

    always_comb begin
        rsp_vld_default: begin
            bus.rsp_vld = '0;
        end
        for (int i = 0; i < N_REQ; i++)
            if (sq_y_vld && out_vld && out_tag == TAG_W'(i)) bus.rsp_vld[i] = 1'b1;
    end
    assign bus.rsp_y = sq_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   err <= 1'b0;
        else if (sq_y_vld != out_vld) err <= 1'b1;
    end

`ifdef ISQRT_ARBITER_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++)
                if (grant[i] && grant_cnt[i] != GCNT_MAX)
                    grant_cnt[i] <= grant_cnt[i] + 1'b1;
        end
    end
`else
    assign grant_cnt = '0;
`endif
endmodule

// File: tb/tb_isqrt_arbiter.sv
// Bench for isqrt_arbiter: drives randomized and directed requests, hosts a
// behavioural pipelined isqrt on the sq_* ports, and scoreboards responses.
module tb_isqrt_arbiter;
    import isqrt_arb_pkg::*;
    localparam int N   = 3;
    localparam int LAT = 16;

    typedef struct {
        int          idx;
        logic [31:0] y;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sq_x_vld, sq_y_vld, err, force_y;
    logic [31:0] sq_x, sq_y;
    logic [N-1:0][GCNT_W-1:0] grant_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t sb[$];
    int mlast;
    int mcnt[N];

    isqrt_arbiter_if #(.N_REQ(N)) bus ();

    isqrt_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sq_x_vld  (sq_x_vld),
        .sq_x      (sq_x),
        .sq_y_vld  (sq_y_vld),
        .sq_y      (sq_y),
        .err       (err),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bit-serial integer square root, used by the stand-in isqrt.
    function automatic logic [31:0] bit_isqrt(input logic [31:0] x);
        logic [31:0] res, t;
        res = '0;
        for (int b = 15; b >= 0; b--) begin
            t = res | (32'd1 << b);
            if ({32'd0, t} * {32'd0, t} <= {32'd0, x}) res = t;
        end
        return res;
    endfunction

    // Reference floor(sqrt(x)) from real arithmetic with integer correction.
    function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
        longint y, xx;
        xx = longint'(x);
        y  = longint'($sqrt(real'(x)));
        while (y * y > xx) y--;
        while ((y + 1) * (y + 1) <= xx) y++;
        return 32'(y);
    endfunction

    // Stand-in pipelined isqrt, not reset: in-flight work survives a DUT reset.
    logic [LAT-1:0]   iv = '0;
    logic [31:0]      iy [LAT];
    always @(posedge clk) begin
        iv[0] <= sq_x_vld;
        iy[0] <= bit_isqrt(sq_x);
        for (int k = 1; k < LAT; k++) begin
            iv[k] <= iv[k-1];
            iy[k] <= iy[k-1];
        end
    end
    assign sq_y_vld = iv[LAT-1] | force_y;
    assign sq_y     = iy[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One bus cycle: drive, then compare the grant against the round-robin model.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0][31:0] xs, output int g);
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        bus.req_vld = v;
        bus.req_x   = xs;
        #1;
        g = -1;
        for (int k = 1; k <= N; k++)
            if (g < 0 && v[(mlast + k) % N]) g = (mlast + k) % N;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_rdy", 64'(bus.req_rdy), 64'(exp_rdy));
        if (g >= 0) begin
            sb.push_back('{idx: g, y: ref_sqrt(xs[g]), cyc: cyc + LAT + 1});
            mlast = g;
            if (mcnt[g] < 16'hFFFF) mcnt[g]++;
        end
    endtask

    task automatic idle(input int n);
        int g;
        logic [N-1:0][31:0] xs;
        for (int i = 0; i < n; i++) begin
            xs = {N{$urandom}};
            step('0, xs, g);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [N-1:0][GCNT_W-1:0] exp_cnt();
        logic [N-1:0][GCNT_W-1:0] e;
        e = '0;
`ifdef ISQRT_ARBITER_PERF_EN
        for (int i = 0; i < N; i++) e[i] = GCNT_W'(mcnt[i]);
`endif
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_vld = '1;
        sb.delete();
        mlast = N - 1;
        for (int i = 0; i < N; i++) mcnt[i] = 0;
        #1;
        check("rst_req_rdy", 64'(bus.req_rdy), 64'd0);
        check("rst_rsp_vld", 64'(bus.rsp_vld), 64'd0);
        check("rst_sq_x_vld", 64'(sq_x_vld), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_grant_cnt", 64'(grant_cnt), 64'd0);
        @(negedge clk);
        bus.req_vld = '0;
        rst_n = 1'b1;
    endtask

    // Response monitor.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL rsp_missing: no response, expected idx %0d y %0d at cycle %0d", sb[0].idx, sb[0].y, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (|bus.rsp_vld) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: rsp_vld %b with nothing outstanding (cycle %0d)", bus.rsp_vld, cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.rsp_vld != N'(1 << e.idx) || bus.rsp_y != e.y || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL rsp: got vld %b y %0d cycle %0d expected idx %0d y %0d cycle %0d",
                                 bus.rsp_vld, bus.rsp_y, cyc, e.idx, e.y, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int g;
        int seq[6];
        logic [N-1:0][31:0] xs;
        logic [N-1:0] v;
        rst_n = 1'b0;
        force_y = 1'b0;
        bus.req_vld = '0;
        bus.req_x = '0;
        mlast = N - 1;
        repeat (2) @(negedge clk);
        do_reset();

        // single request: 144 -> 12 after LATENCY+1
        xs = '0; xs[0] = 32'd144;
        step(3'b001, xs, g);
        idle(1);
        wait_drain();

        // fairness with all three held
        do_reset();
        for (int i = 0; i < 6; i++) begin
            xs[0] = $urandom; xs[1] = $urandom; xs[2] = $urandom;
            step(3'b111, xs, g);
            seq[i] = g;
        end
        for (int i = 0; i < 6; i++) check("fair_order", 64'(seq[i]), 64'(i % 3));
        idle(1);
        wait_drain();

        // idle gating around x=81
        xs = '0; xs[0] = 32'd81;
        step(3'b001, xs, g);
        idle(1);
        check("gate_vld_first", 64'(sq_x_vld), 64'd1);
        check("gate_x_first", 64'(sq_x), 64'd81);
        for (int i = 0; i < 20; i++) begin
            idle(1);
            check("gate_vld", 64'(sq_x_vld), 64'd0);
            check("gate_x", 64'(sq_x), 64'd81);
        end
        check("gate_err", 64'(err), 64'd0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            v = N'($urandom_range(0, 7));
            for (int r = 0; r < N; r++) begin
                case ($urandom_range(0, 7))
                    0:       xs[r] = 32'd0;
                    1:       xs[r] = 32'hFFFF_FFFF;
                    2:       xs[r] = 32'd1;
                    default: xs[r] = $urandom;
                endcase
            end
            step(v, xs, g);
        end
        idle(1);
        wait_drain();
        check("rand_err", 64'(err), 64'd0);
        check("rand_grant_cnt", 64'(grant_cnt), 64'(exp_cnt()));

        // mismatch: fake isqrt valid with empty pipeline
        idle(LAT + 3);
        @(negedge clk);
        force_y = 1'b1;
        #1;
        check("mis_rsp_vld", 64'(bus.rsp_vld), 64'd0);
        @(negedge clk);
        force_y = 1'b0;
        #1;
        check("mis_err", 64'(err), 64'd1);
        idle(3);
        check("mis_err_sticky", 64'(err), 64'd1);
        do_reset();
        idle(3);
        check("err_cleared", 64'(err), 64'd0);

        // reset with four requests in flight
        for (int i = 0; i < 4; i++) begin
            xs[0] = $urandom; xs[1] = $urandom; xs[2] = $urandom;
            step(3'b111, xs, g);
        end
        idle(5);
        do_reset();
        idle(25);
        check("flight_err", 64'(err), 64'd1);
        do_reset();
        xs[0] = $urandom; xs[1] = $urandom; xs[2] = $urandom;
        step(3'b111, xs, g);
        check("flight_first_grant", 64'(g), 64'd0);
        idle(1);
        wait_drain();

`ifdef ISQRT_ARBITER_PERF_EN
        xs = '0;
        for (int i = 0; i < 70000; i++) begin
            xs[1] = $urandom;
            step(3'b010, xs, g);
        end
        idle(1);
        wait_drain();
        check("cnt_sat", 64'(grant_cnt[1]), 64'hFFFF);
`endif
        check("final_grant_cnt", 64'(grant_cnt), 64'(exp_cnt()));
        check("final_err", 64'(err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
